// File: rtl/imm_enc_pkg.sv
// ============================================================================
// Module  : imm_enc_pkg
// Purpose : Shared definitions for the RISC-V immediate encoder.
//           - Format select codes IMM_I..IMM_J, shared with imm_gen and control.
//           - Per-format masks of the instruction bits that hold immediate data.
//           - Range/alignment check of an immediate for a given format.
//           - Reference immediate decoder (imm_gen behaviour), used by the
//             optional round-trip self-check (IMM_ENC_ROUNDTRIP_EN).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package imm_enc_pkg;

  // Format select codes; values 5..7 are illegal.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Instruction bits owned by the immediate for each format.
  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  function automatic logic [31:0] imm_field_mask(input logic [2:0] sel);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (sel)
      IMM_I:   m = MASK_I;
      IMM_S:   m = MASK_S;
      IMM_B:   m = MASK_B;
      IMM_U:   m = MASK_U;
      IMM_J:   m = MASK_J;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // 1 when the immediate cannot be represented exactly in the selected format.
  // "All upper bits equal" is the sign-extension test for the format's width.
  function automatic logic imm_range_err(input logic [2:0] sel, input logic [31:0] imm);
    logic e;
    e = 1'b1;
    case (sel)
      IMM_I, IMM_S: e = !((&imm[31:11]) || (~|imm[31:11]));
      IMM_B:        e = !((&imm[31:12]) || (~|imm[31:12])) || imm[0];
      IMM_U:        e = |imm[11:0];
      IMM_J:        e = !((&imm[31:20]) || (~|imm[31:20])) || imm[0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  // Immediate decoder, bit-for-bit the behaviour of imm_gen.
  function automatic logic [31:0] imm_decode(input logic [2:0] sel, input logic [31:0] instr);
    logic [31:0] v;
    v = 32'h0000_0000;
    case (sel)
      IMM_I:   v = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   v = {instr[31:12], 12'h000};
      IMM_J:   v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_enc_pack.sv
// ============================================================================
// Module  : imm_enc_pack
// Purpose : Combinational immediate packer. Places the selected format's
//           immediate bits into a base instruction word and flags immediates
//           that are out of range or misaligned for the format.
// Ports   : sel       in  3   format select (IMM_I..IMM_J, 5..7 illegal)
//           imm       in  32  signed immediate
//           base      in  32  instruction word supplying all non-imm bits
//           instr     out 32  packed word (base unchanged for illegal sel)
//           range_err out 1   immediate not representable, or sel illegal
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_enc_pack
  import imm_enc_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        range_err
);

  logic [31:0] field;
  logic [31:0] mask;

  always_comb begin
    field = 32'h0000_0000;
    case (sel)
      IMM_I:   field = {imm[11:0], 20'h00000};
      IMM_S:   field = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
      IMM_B:   field = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
      IMM_U:   field = {imm[31:12], 12'h000};
      IMM_J:   field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
      default: field = 32'h0000_0000;
    endcase
  end

  // Out-of-range immediates still get packed (truncated); only the flag tells.
  assign mask      = imm_field_mask(sel);
  assign instr     = (base & ~mask) | field;
  assign range_err = imm_range_err(sel, imm);

endmodule

`default_nettype wire

// File: rtl/imm_enc.sv
// ============================================================================
// Module  : imm_enc
// Purpose : Two-stage valid/ready pipeline around imm_enc_pack. Packs a
//           signed immediate into the I/S/B/U/J bit positions of a base
//           instruction word, flags bad immediates and counts flagged results
//           in a saturating counter.
// Config  : IMM_ENC_ROUNDTRIP_EN - when defined, the S2 result is decoded
//           again and out_rt_fail reports a mismatch with the S2 immediate.
//           When undefined, out_rt_fail is tied to 0.
// Params  : CNT_W        width of err_cnt
// Ports   : clk          in   1      rising-edge clock
//           rst_n        in   1      asynchronous active-low reset
//           in_valid     in   1      request valid
//           in_ready     out  1      request accepted on in_valid && in_ready
//           in_sel       in   3      format select
//           in_imm       in   32     signed immediate
//           in_base      in   32     base instruction word
//           out_valid    out  1      result valid
//           out_ready    in   1      result consumed on out_valid && out_ready
//           out_instr    out  32     packed instruction word
//           out_err      out  1      range/alignment/select error
//           out_rt_fail  out  1      round-trip mismatch
//           err_cnt      out  CNT_W  saturating count of consumed errored results
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic             out_rt_fail,
  output logic [CNT_W-1:0] err_cnt
);

  // S1 state
  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_sel_q,   s1_sel_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  logic [31:0] s1_base_q,  s1_base_d;

  // S2 state (drives out_*)
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        s2_load;
  logic        s1_load;
  logic [31:0] pack_instr;
  logic        pack_err;

  // Each stage may load when empty or when the stage after it is draining.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  imm_enc_pack u_pack (
    .sel       (s1_sel_q),
    .imm       (s1_imm_q),
    .base      (s1_base_q),
    .instr     (pack_instr),
    .range_err (pack_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sel_d  = in_sel;
        s1_imm_d  = in_imm;
        s1_base_d = in_base;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = pack_instr;
        s2_err_d   = pack_err;
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= 3'd0;
      s1_imm_q   <= 32'h0000_0000;
      s1_base_q  <= 32'h0000_0000;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'h0000_0000;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

`ifdef IMM_ENC_ROUNDTRIP_EN
  // S2 keeps its own copy of sel/imm so the packed word can be decoded again.
  logic [2:0]  s2_sel_q, s2_sel_d;
  logic [31:0] s2_imm_q, s2_imm_d;
  logic [31:0] rt_imm;

  always_comb begin
    s2_sel_d = s2_sel_q;
    s2_imm_d = s2_imm_q;
    if (s2_load && s1_valid_q) begin
      s2_sel_d = s1_sel_q;
      s2_imm_d = s1_imm_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sel_q <= 3'd0;
      s2_imm_q <= 32'h0000_0000;
    end else begin
      s2_sel_q <= s2_sel_d;
      s2_imm_q <= s2_imm_d;
    end
  end

  assign rt_imm      = imm_decode(s2_sel_q, s2_instr_q);
  // Errored results are truncated by design, so only clean ones are checked.
  assign out_rt_fail = s2_valid_q && !s2_err_q && (rt_imm != s2_imm_q);
`else
  assign out_rt_fail = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_enc.sv
// ============================================================================
// Module  : tb_imm_enc
// Purpose : Scoreboard bench for imm_enc. Requests are driven through a
//           handshake task that pushes the expected result; a monitor pops
//           and compares on every output handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_enc;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_sel = 3'd0;
  logic [31:0]      in_imm = 32'h0;
  logic [31:0]      in_base = 32'h0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_instr;
  logic             out_err;
  logic             out_rt_fail;
  logic [CNT_W-1:0] err_cnt;

  imm_enc #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_imm      (in_imm),
    .in_base     (in_base),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_err     (out_err),
    .out_rt_fail (out_rt_fail),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cnt_model = 0;
  bit   rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Which immediate bit lands in instruction bit b (-1: bit comes from base).
  function automatic int src_bit(input int sel, input int b);
    int s;
    s = -1;
    case (sel)
      0: if (b >= 20) s = b - 20;
      1: begin
        if (b >= 25) s = b - 20;
        else if (b >= 7 && b <= 11) s = b - 7;
      end
      2: begin
        if (b == 31) s = 12;
        else if (b >= 25) s = b - 20;
        else if (b >= 8 && b <= 11) s = b - 7;
        else if (b == 7) s = 11;
      end
      3: if (b >= 12) s = b;
      4: begin
        if (b == 31) s = 20;
        else if (b >= 21) s = b - 20;
        else if (b == 20) s = 11;
        else if (b >= 12) s = b;
      end
      default: s = -1;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] model_pack(input int sel, input logic [31:0] imm,
                                             input logic [31:0] base);
    logic [31:0] r;
    int src;
    for (int b = 0; b < 32; b++) begin
      src = src_bit(sel, b);
      r[b] = (src < 0) ? base[b] : imm[src];
    end
    return r;
  endfunction

  // Representable means: fits the signed range of the format and, where the
  // low bit is implicit, is even; U needs the low 12 bits clear.
  function automatic logic model_err(input int sel, input logic [31:0] imm);
    int signed   s;
    logic [31:0] u;
    logic        e;
    s = $signed(imm);
    u = imm;
    case (sel)
      0, 1:    e = !(s >= -2048 && s <= 2047);
      2:       e = !(s >= -4096 && s <= 4095 && (s % 2) == 0);
      3:       e = (u % 32'd4096) != 0;
      4:       e = !(s >= -1048576 && s <= 1048575 && (s % 2) == 0);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] ei, input logic ee);
    bit ok;
    ok = 1'b0;
    in_sel   = sel;
    in_imm   = imm;
    in_base  = base;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) sb.push_back('{ei, ee});
    else fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    send(sel, imm, base, model_pack(int'(sel), imm, base), model_err(int'(sel), imm));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_err", {31'b0, out_err}, {31'b0, e.err});
        chk("out_rt_fail", {31'b0, out_rt_fail}, 32'd0);
        chk("err_cnt", {30'b0, err_cnt}, cnt_model);
        if (e.err && cnt_model < CNT_MAX) cnt_model++;
      end
    end
  end

  // Random output backpressure, changed only at posedge+1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  rs;
    logic [31:0] ri;
    logic [31:0] ea;
    int          r;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_out_rt_fail", {31'b0, out_rt_fail}, 32'd0);
    chk("rst_err_cnt", {30'b0, err_cnt}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with latency check on the first
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    @(negedge clk);
    chk("latency_not_early", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    send(3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    send(3'd2, 32'h0000_0002, 32'h0000_0063, 32'h0000_0163, 1'b0);
    send(3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    drain();
    chk("err_cnt_after_b", {30'b0, err_cnt}, 32'd1);
    send(3'd3, 32'h1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0);
    send(3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    send(3'd3, 32'h1234_5001, 32'h0000_00B7, 32'h1234_50B7, 1'b1);
    send(3'd5, 32'h0000_0040, 32'h0000_0013, 32'h0000_0013, 1'b1);
    drain();

    // Backpressure: two requests fill the pipe, the third must wait
    out_ready = 1'b0;
    ea = model_pack(1, 32'hFFFF_F812, 32'h0000_2023);
    send(3'd1, 32'hFFFF_F812, 32'h0000_2023, ea, 1'b0);
    send_m(3'd0, 32'h0000_07FF, 32'h0000_0013);
    in_sel   = 3'd4;
    in_imm   = 32'hFFF0_0000;
    in_base  = 32'h0000_00EF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_instr_hold", out_instr, ea);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_m(3'd4, 32'hFFF0_0000, 32'h0000_00EF);
    drain();

    // Asynchronous reset with requests in flight
    out_ready = 1'b0;
    send_m(3'd6, 32'h0000_0001, 32'h0000_0033);
    send_m(3'd2, 32'h0000_1001, 32'h0000_0063);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_err_cnt", {30'b0, err_cnt}, 32'd0);
    sb.delete();
    cnt_model = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Saturation: five errored results on a 2-bit counter
    send_m(3'd7, 32'h0, 32'h0000_0013);
    send_m(3'd0, 32'h0000_0800, 32'h0000_0013);
    send_m(3'd4, 32'h0010_0000, 32'h0000_006F);
    send_m(3'd3, 32'h0000_0FFF, 32'h0000_0037);
    send_m(3'd1, 32'hFFFF_F7FF, 32'h0000_0023);
    drain();
    chk("err_cnt_saturated", {30'b0, err_cnt}, 32'd3);

    // Randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom % 10);
      rs = (r < 8) ? 3'(r % 5) : 3'(5 + ($urandom % 3));
      case ($urandom % 4)
        0:       ri = $urandom;
        1:       ri = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       ri = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: ri = $urandom & 32'hFFFF_F000;
      endcase
      if (($urandom % 2) == 0 && (rs == 3'd2 || rs == 3'd4)) ri[0] = 1'b0;
      send_m(rs, ri, $urandom);
      if (($urandom % 8) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("final_err_cnt", {30'b0, err_cnt}, cnt_model);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
